// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl
//   Initiator side of the Regbank port set, between decode and execute.
//   Accepts an issue request (sr1, sr2, dr, wen), drives the Regbank read
//   addresses, and captures both operands one cycle later. A writeback that
//   arrives in the same cycle is forwarded into the captured operands.
//   An 8-entry scoreboard of pending destinations stalls RAW hazards.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready    issue handshake; req_sr1/req_sr2/req_dr/req_wen
//   wb_valid/wb_dr/wb_data writeback (always accepted)
//   rb_sr1/rb_sr2          Regbank read addresses (registered)
//   rb_rdData1/rb_rdData2  Regbank combinational read data
//   rb_write/rb_dr/rb_wrData  Regbank write port (pass-through of writeback)
//   op_valid/op_ready      operand bundle handshake; op_a, op_b, op_dr
//   sb_busy                scoreboard, bit i = write to register i pending
module operand_fetch_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_sr1,
  input  logic [ADDR_W-1:0]        req_sr2,
  input  logic [ADDR_W-1:0]        req_dr,
  input  logic                     req_wen,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_dr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic [ADDR_W-1:0]        rb_sr1,
  output logic [ADDR_W-1:0]        rb_sr2,
  input  logic [DATA_W-1:0]        rb_rdData1,
  input  logic [DATA_W-1:0]        rb_rdData2,
  output logic                     rb_write,
  output logic [ADDR_W-1:0]        rb_dr,
  output logic [DATA_W-1:0]        rb_wrData,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b,
  output logic [ADDR_W-1:0]        op_dr,
  output logic [(2**ADDR_W)-1:0]   sb_busy
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   dr_q;
  logic                accept;
  logic                fwd1;
  logic                fwd2;
  logic [NREG-1:0]     sb_next;

  // Hazard test looks at the pre-edge scoreboard only, so a writeback
  // clearing a bit unblocks issue on the following cycle.
  always_comb begin
    req_ready = (state == IDLE) && !sb_busy[req_sr1] && !sb_busy[req_sr2];
    accept    = req_valid && req_ready;
  end

  // Clear from writeback first, then set from issue: set wins on a tie.
  always_comb begin
    sb_next = sb_busy;
    if (wb_valid)
      sb_next[wb_dr] = 1'b0;
    if (accept && req_wen)
      sb_next[req_dr] = 1'b1;
  end

  // rb_sr1/rb_sr2 hold the latched source indices during FETCH.
  always_comb begin
    fwd1 = wb_valid && (wb_dr == rb_sr1);
    fwd2 = wb_valid && (wb_dr == rb_sr2);
  end

  always_comb begin
    rb_write  = wb_valid && !reset;
    rb_dr     = wb_dr;
    rb_wrData = wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sb_busy  <= '0;
      rb_sr1   <= '0;
      rb_sr2   <= '0;
      dr_q     <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_dr    <= '0;
    end else begin
      sb_busy <= sb_next;
      case (state)
        IDLE: begin
          if (accept) begin
            rb_sr1 <= req_sr1;
            rb_sr2 <= req_sr2;
            dr_q   <= req_dr;
            state  <= FETCH;
          end
        end
        FETCH: begin
          op_a     <= fwd1 ? wb_data : rb_rdData1;
          op_b     <= fwd2 ? wb_data : rb_rdData2;
          op_dr    <= dr_q;
          op_valid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
module tb_operand_fetch_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_sr1, req_sr2, req_dr;
  logic              req_wen;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rb_sr1, rb_sr2;
  logic [DATA_W-1:0] rb_rdData1, rb_rdData2;
  logic              rb_write;
  logic [ADDR_W-1:0] rb_dr;
  logic [DATA_W-1:0] rb_wrData;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic [ADDR_W-1:0] op_dr;
  logic [7:0]        sb_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] dr;
  } bundle_t;

  bundle_t exp_q[$];

  always #5 clk = ~clk;

  operand_fetch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sr1(req_sr1), .req_sr2(req_sr2), .req_dr(req_dr), .req_wen(req_wen),
    .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data),
    .rb_sr1(rb_sr1), .rb_sr2(rb_sr2),
    .rb_rdData1(rb_rdData1), .rb_rdData2(rb_rdData2),
    .rb_write(rb_write), .rb_dr(rb_dr), .rb_wrData(rb_wrData),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_dr(op_dr),
    .sb_busy(sb_busy)
  );

  // Regbank model: combinational read, write on rising edge.
  logic [DATA_W-1:0] regs [8];
  initial for (int i = 0; i < 8; i++) regs[i] = '0;
  assign rb_rdData1 = regs[rb_sr1];
  assign rb_rdData2 = regs[rb_sr2];
  always @(posedge clk) if (rb_write) regs[rb_dr] <= rb_wrData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected bundle at every output handshake.
  always @(negedge clk) begin
    if (!reset && op_valid && op_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bundle_unexpected: got a=%0h b=%0h dr=%0h, none expected",
                 op_a, op_b, op_dr);
      end else begin
        bundle_t e;
        e = exp_q.pop_front();
        if (op_a !== e.a || op_b !== e.b || op_dr !== e.dr) begin
          failures++;
          $display("FAIL bundle: got a=%0h b=%0h dr=%0h expected a=%0h b=%0h dr=%0h",
                   op_a, op_b, op_dr, e.a, e.b, e.dr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    wb_valid = 1'b1; wb_dr = d; wb_data = v;
    tick();
    wb_valid = 1'b0;
  endtask

  // Presents a request and waits (bounded) for acceptance; returns at
  // posedge+1 of the accept edge, i.e. in the FETCH cycle.
  task automatic issue(input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                       input logic [ADDR_W-1:0] d, input logic w,
                       input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb,
                       input bit push);
    bit done = 0;
    req_sr1 = s1; req_sr2 = s2; req_dr = d; req_wen = w; req_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (req_ready) begin
        if (push) exp_q.push_back('{a: ea, b: eb, dr: d});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL issue_timeout: got no accept, expected accept within 20 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 0; req_sr1 = 0; req_sr2 = 0; req_dr = 0; req_wen = 0;
    wb_valid = 1'b1; wb_dr = 3'd1; wb_data = 16'hDEAD; op_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_op_valid", op_valid, 0);
    chk("reset_sb_busy", sb_busy, 0);
    chk("reset_op_a", op_a, 0);
    chk("reset_rb_sr1", rb_sr1, 0);
    chk("reset_rb_write_forced", rb_write, 0);
    wb_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Preload through the writeback path; writes to non-busy regs keep sb 0.
    wb_write(3'd2, 16'd20);
    wb_write(3'd3, 16'd30);
    wb_write(3'd1, 16'd7);
    chk("preload_sb_zero", sb_busy, 0);

    // 1: basic fetch
    issue(3'd2, 3'd3, 3'd5, 1'b1, 16'd20, 16'd30, 1);
    chk("t1_fetch_no_valid", op_valid, 0);
    chk("t1_sb_busy", sb_busy, 8'h20);
    tick();
    chk("t1_op_valid", op_valid, 1);
    tick();
    chk("t1_back_idle", op_valid, 0);

    // 2: RAW stall on r5, released by writeback one cycle later
    req_sr1 = 3'd5; req_sr2 = 3'd3; req_dr = 3'd6; req_wen = 1'b0; req_valid = 1'b1;
    #1;
    chk("t2_stall", req_ready, 0);
    wb_valid = 1'b1; wb_dr = 3'd5; wb_data = 16'd50;
    #1;
    chk("t2_stall_same_cycle_wb", req_ready, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("t2_sb_cleared", sb_busy, 0);
    chk("t2_ready_next", req_ready, 1);
    exp_q.push_back('{a: 16'd50, b: 16'd30, dr: 3'd6});
    tick();
    req_valid = 1'b0;
    repeat (2) tick();

    // 3: forward writeback during FETCH
    issue(3'd2, 3'd2, 3'd7, 1'b1, 16'd99, 16'd99, 1);
    wb_valid = 1'b1; wb_dr = 3'd2; wb_data = 16'd99;
    tick();
    wb_valid = 1'b0;
    chk("t3_sb_busy", sb_busy, 8'h80);
    tick();

    // 4: backpressure; also a writeback clears sb[7] while in HOLD
    op_ready = 1'b0;
    issue(3'd3, 3'd1, 3'd6, 1'b0, 16'd30, 16'd7, 1);
    tick();
    req_sr1 = 3'd0; req_sr2 = 3'd1; req_valid = 1'b1; req_wen = 1'b0;
    wb_valid = 1'b1; wb_dr = 3'd7; wb_data = 16'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_hold_valid", op_valid, 1);
      chk("t4_hold_a", op_a, 16'd30);
      chk("t4_hold_b", op_b, 16'd7);
      chk("t4_hold_dr", op_dr, 3'd6);
      chk("t4_hold_no_ready", req_ready, 0);
      tick();
      wb_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("t4_sb_cleared_in_hold", sb_busy, 0);
    op_ready = 1'b1;
    tick();
    chk("t4_idle", op_valid, 0);

    // 5: same-edge set and clear of bit 4 -> set wins
    req_sr1 = 3'd3; req_sr2 = 3'd3; req_dr = 3'd4; req_wen = 1'b1; req_valid = 1'b1;
    wb_valid = 1'b1; wb_dr = 3'd4; wb_data = 16'd44;
    #1;
    chk("t5_ready", req_ready, 1);
    exp_q.push_back('{a: 16'd30, b: 16'd30, dr: 3'd4});
    tick();
    wb_valid = 1'b0; req_valid = 1'b0;
    chk("t5_set_wins", sb_busy, 8'h10);
    repeat (2) tick();

    // 6: reset during FETCH discards everything
    issue(3'd2, 3'd3, 3'd0, 1'b1, 16'd0, 16'd0, 0);
    chk("t6_sb_before_reset", sb_busy, 8'h11);
    wb_valid = 1'b1; wb_dr = 3'd2; wb_data = 16'h1234;
    reset = 1'b1;
    #1;
    chk("t6_op_valid", op_valid, 0);
    chk("t6_sb_busy", sb_busy, 0);
    chk("t6_rb_write", rb_write, 0);
    tick();
    wb_valid = 1'b0;
    reset = 1'b0;
    tick();
    // Back in IDLE: r4 no longer busy, so this is accepted straight away.
    issue(3'd4, 3'd4, 3'd1, 1'b0, 16'd44, 16'd44, 1);
    repeat (3) tick();
    chk("end_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
